calc_requester: RTL

Initiator side of the four-signal compute handshake (ready / data_valid / calc_done / read_done) used by the floating-point power unit and its siblings. It accepts tagged operand pairs from an upstream valid/ready stream and issues each pair to one downstream compute unit. It holds the operands stable for the whole transaction, collects the result, and retires it with read_done. It then returns the result with its tag on a downstream valid/ready stream, one transaction in flight at a time.

---
 rtl/calc_req_pkg.sv | 26 ++
 rtl/calc_req_if.sv | 53 +++++
 rtl/calc_req_slot.sv | 51 +++++
 rtl/calc_requester.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/calc_req_pkg.sv
// calc_req_pkg
// Shared definitions for the compute-handshake requester:
//   - calc_state_e : requester FSM states (HUNG exists only when
//                    CALC_REQ_TIMEOUT_EN is defined)
//   - CALC_NAN     : quiet-NaN result reported for a hung transaction
//   - DEF_TAG_W    : default transaction tag width
//   - DEF_TIMEOUT_CYCLES : default WAIT_DONE watchdog limit
package calc_req_pkg;

   localparam int DEF_TAG_W          = 4;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam logic [31:0] CALC_NAN  = 32'h7fc00000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_ACK       = 3'd3,
      ST_DRAIN     = 3'd4
`ifdef CALC_REQ_TIMEOUT_EN
      ,
      ST_HUNG      = 3'd5
`endif
   } calc_state_e;

endpackage

// File: rtl/calc_req_if.sv
// calc_req_if
// Bundles the three handshakes seen by calc_requester:
//   in_*   : upstream valid/ready operand stream (a, b, tag)
//   unit_* : four-signal compute handshake (ready / data_valid /
//            calc_done / read_done) plus operands and result
//   out_*  : downstream valid/ready result stream (result, tag)
// Modports:
//   master : the requester side (calc_requester)
//   slave  : everything around it (upstream, compute unit, downstream)
interface calc_req_if
   import calc_req_pkg::*;
#(
   parameter int TAG_W = DEF_TAG_W
);

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;

   logic             unit_ready;
   logic             unit_data_valid;
   logic [31:0]      unit_op_a;
   logic [31:0]      unit_op_b;
   logic             unit_calc_done;
   logic [31:0]      unit_result;
   logic             unit_read_done;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      input  in_valid, in_a, in_b, in_tag,
      output in_ready,
      input  unit_ready, unit_calc_done, unit_result,
      output unit_data_valid, unit_op_a, unit_op_b, unit_read_done,
      output out_valid, out_result, out_tag,
      input  out_ready
   );

   modport slave (
      output in_valid, in_a, in_b, in_tag,
      input  in_ready,
      output unit_ready, unit_calc_done, unit_result,
      input  unit_data_valid, unit_op_a, unit_op_b, unit_read_done,
      input  out_valid, out_result, out_tag,
      output out_ready
   );

endinterface

// File: rtl/calc_req_slot.sv
// calc_req_slot
// One-entry holding register with a valid flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : capture data_i and mark the slot full
//   clear_i  : mark the slot empty (load wins if both are high)
//   data_i   : W-bit entry to capture
//   valid_o  : slot full
//   data_o   : held entry (reset 0)
module calc_req_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // The owner never loads a full slot, so load and clear do not
   // collide in practice; load is given priority anyway.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/calc_requester.sv
// calc_requester
// Initiator of the four-signal compute handshake. Takes one tagged
// operand pair at a time from the upstream stream, drives it to the
// compute unit, collects the result with read_done, and offers the
// result plus tag on the downstream stream.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (shared with the unit)
//   bus      : calc_req_if.master (upstream, unit and downstream handshakes)
//   busy     : FSM not idle or either slot occupied
// Optional feature: CALC_REQ_TIMEOUT_EN adds a WAIT_DONE watchdog of
// TIMEOUT_CYCLES cycles; on expiry the FSM parks in HUNG, reports a NaN
// result with the current tag and refuses new input until reset.
module calc_requester
   import calc_req_pkg::*;
#(
`ifdef CALC_REQ_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic       clk,
   input  logic       rst,
   calc_req_if.master bus,
   output logic       busy
);

   calc_state_e      state_q, state_d;
   logic [31:0]      opA_q, opA_d;
   logic [31:0]      opB_q, opB_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic             inValid, inLoad, inClear;
   logic [TAG_W+63:0] inData;
   logic             outValid, outLoad, outClear;
   logic [TAG_W+31:0] outData, outLoadData;
   logic             dataValid, readDone;

`ifdef CALC_REQ_TIMEOUT_EN
   logic [15:0]      cnt_q, cnt_d;
`endif

   // Input slot holds {a, b, tag}; it stays full for the whole
   // transaction and only frees once the result has been captured.
   calc_req_slot #(.W(TAG_W + 64)) inSlot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (inLoad),
      .clear_i (inClear),
      .data_i  ({bus.in_a, bus.in_b, bus.in_tag}),
      .valid_o (inValid),
      .data_o  (inData)
   );

   // Output slot holds {result, tag} until the downstream takes it.
   calc_req_slot #(.W(TAG_W + 32)) outSlot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (outLoad),
      .clear_i (outClear),
      .data_i  (outLoadData),
      .valid_o (outValid),
      .data_o  (outData)
   );

`ifdef CALC_REQ_TIMEOUT_EN
   assign bus.in_ready = !inValid && (state_q != ST_HUNG);
`else
   assign bus.in_ready = !inValid;
`endif
   assign inLoad   = bus.in_valid && bus.in_ready;
   assign outClear = outValid && bus.out_ready;

   // Transaction sequencing. data_valid and read_done are decoded from
   // the state and the unit's live inputs so each lasts exactly the one
   // cycle in which the matching transition is taken. Capture requires
   // an empty output slot, so calc_done simply stays high (backpressuring
   // the unit) while the downstream has not yet taken the previous result.
   always_comb begin
      state_d     = state_q;
      opA_d       = opA_q;
      opB_d       = opB_q;
      tag_d       = tag_q;
      inClear     = 1'b0;
      outLoad     = 1'b0;
      outLoadData = {bus.unit_result, tag_q};
      dataValid   = 1'b0;
      readDone    = 1'b0;
`ifdef CALC_REQ_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (inValid) begin
               opA_d   = inData[TAG_W+63 -: 32];
               opB_d   = inData[TAG_W+31 -: 32];
               tag_d   = inData[TAG_W-1:0];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.unit_ready) begin
               dataValid = 1'b1;
               state_d   = ST_WAIT_DONE;
`ifdef CALC_REQ_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         ST_WAIT_DONE: begin
            if (bus.unit_calc_done && !outValid) begin
               outLoad  = 1'b1;
               readDone = 1'b1;
               state_d  = ST_ACK;
            end
`ifdef CALC_REQ_TIMEOUT_EN
            else if (cnt_q >= 16'(TIMEOUT_CYCLES - 1)) begin
               // Wait for room in the output slot so a pending result
               // is never overwritten by the NaN report.
               if (!outValid) begin
                  outLoad     = 1'b1;
                  outLoadData = {CALC_NAN, tag_q};
                  state_d     = ST_HUNG;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         ST_ACK: begin
            inClear = 1'b1;
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Do not return to IDLE while the old calc_done is still
            // visible, or it would be captured a second time.
            if (!bus.unit_calc_done && bus.unit_ready) begin
               state_d = ST_IDLE;
            end
         end
`ifdef CALC_REQ_TIMEOUT_EN
         ST_HUNG: begin
            state_d = ST_HUNG;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and operand/tag registers; operands stay frozen from IDLE
   // until the next transaction is picked up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         tag_q   <= tag_d;
      end
   end

`ifdef CALC_REQ_TIMEOUT_EN
   // Watchdog counter for the WAIT_DONE state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign bus.unit_data_valid = dataValid;
   assign bus.unit_read_done  = readDone;
   assign bus.unit_op_a       = opA_q;
   assign bus.unit_op_b       = opB_q;
   assign bus.out_valid       = outValid;
   assign bus.out_result      = outData[TAG_W+31 -: 32];
   assign bus.out_tag         = outData[TAG_W-1:0];
   assign busy                = (state_q != ST_IDLE) || inValid || outValid;

endmodule
